// File: rtl/neighbor_stream_arbiter_pkg.sv
// Shared constants, lane state and beat payload types for the neighbor stream arbiter.
package neighbor_stream_arbiter_pkg;

  localparam int unsigned NUM_BANKS      = 4;
  localparam int unsigned NUM_PE         = 4;
  localparam int unsigned NBR_ID_W       = 14;
  localparam int unsigned ITER_W         = 4;
  localparam int unsigned TIMEOUT_CYCLES = 64;
  localparam int unsigned PE_TAG_W       = $clog2(NUM_PE);
  localparam int unsigned BANK_W         = $clog2(NUM_BANKS);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } lane_state_e;

  typedef struct packed {
    logic                valid;
    logic [PE_TAG_W-1:0] pe_tag;
    logic                sos;
    logic                eos;
    logic [ITER_W-1:0]   num_iter;
    logic [NBR_ID_W-1:0] nbr_id;
  } bank_beat_t;

  typedef struct packed {
    logic                valid;
    logic                sos;
    logic                eos;
    logic [ITER_W-1:0]   num_iter;
    logic [NBR_ID_W-1:0] nbr_id;
    logic [BANK_W-1:0]   src_bank;
  } pe_beat_t;

  // Bank index offset by k, wrapping modulo NUM_BANKS.
  function automatic logic [BANK_W-1:0] bank_add(input logic [BANK_W-1:0] b,
                                                 input int unsigned k);
    return BANK_W'((32'(b) + k) % NUM_BANKS);
  endfunction

endpackage

// File: rtl/neighbor_stream_arbiter_if.sv
// Bank-side and PE-side bundle of the neighbor stream arbiter; slave is the arbiter view.
interface neighbor_stream_arbiter_if;
  import neighbor_stream_arbiter_pkg::*;

  logic [NUM_BANKS-1:0]          bank_valid;
  logic [NUM_BANKS*PE_TAG_W-1:0] bank_pe_tag;
  logic [NUM_BANKS-1:0]          bank_sos;
  logic [NUM_BANKS-1:0]          bank_eos;
  logic [NUM_BANKS*ITER_W-1:0]   bank_num_iter;
  logic [NUM_BANKS*NBR_ID_W-1:0] bank_nbr_id;
  logic [NUM_BANKS-1:0]          bank_ready;
  logic [NUM_PE-1:0]             pe_valid;
  logic [NUM_PE-1:0]             pe_sos;
  logic [NUM_PE-1:0]             pe_eos;
  logic [NUM_PE*ITER_W-1:0]      pe_num_iter;
  logic [NUM_PE*NBR_ID_W-1:0]    pe_nbr_id;
  logic [NUM_PE*BANK_W-1:0]      pe_src_bank;
  logic                          proto_err;
  logic [NUM_PE-1:0]             timeout_err;

  modport master (
    output bank_valid, bank_pe_tag, bank_sos, bank_eos, bank_num_iter, bank_nbr_id,
    input  bank_ready, pe_valid, pe_sos, pe_eos, pe_num_iter, pe_nbr_id, pe_src_bank,
    input  proto_err, timeout_err
  );

  modport slave (
    input  bank_valid, bank_pe_tag, bank_sos, bank_eos, bank_num_iter, bank_nbr_id,
    output bank_ready, pe_valid, pe_sos, pe_eos, pe_num_iter, pe_nbr_id, pe_src_bank,
    output proto_err, timeout_err
  );

endinterface

// File: rtl/neighbor_lane_rr_arb.sv
// One PE lane: round-robin stream lock, owner tracking and registered output beat.
// Stall watchdog is built only when NEIGHBOR_ARB_TIMEOUT_EN is defined.
module neighbor_lane_rr_arb
  import neighbor_stream_arbiter_pkg::*;
#(
  parameter int unsigned LANE = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  bank_beat_t [NUM_BANKS-1:0]  beats,
  output logic [NUM_BANKS-1:0]        grant_c,
  output logic                        proto_c,
  output pe_beat_t                    beat,
  output logic                        timeout_err
);

  localparam logic [PE_TAG_W-1:0] TAG = PE_TAG_W'(LANE);

  lane_state_e          state, state_n;
  logic [BANK_W-1:0]    rr_ptr, rr_n, owner, owner_n, sel_c;
  logic                 accept_c, found_c, timeout_hit_c;
  logic [NUM_BANKS-1:0] sos_req_c;
  bank_beat_t           own_c;

  assign own_c = beats[owner];

  // Stream-start requests for this lane and illegal mid-stream beats on an idle lane.
  always_comb begin : req_decode
    sos_req_c = '0;
    proto_c   = 1'b0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (beats[b].valid && beats[b].pe_tag == TAG) begin
        sos_req_c[b] = beats[b].sos;
        if (state == IDLE && !beats[b].sos) proto_c = 1'b1;
      end
    end
  end

  always_comb begin : next_state
    state_n  = state;
    rr_n     = rr_ptr;
    owner_n  = owner;
    grant_c  = '0;
    accept_c = 1'b0;
    found_c  = 1'b0;
    sel_c    = owner;
    case (state)
      IDLE: begin
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
          if (!found_c && sos_req_c[bank_add(rr_ptr, i)]) begin
            found_c = 1'b1;
            sel_c   = bank_add(rr_ptr, i);
          end
        end
        if (found_c) begin
          grant_c[sel_c] = 1'b1;
          accept_c       = 1'b1;
          if (beats[sel_c].eos) begin
            rr_n = bank_add(sel_c, 1);
          end else begin
            state_n = STREAM;
            owner_n = sel_c;
          end
        end
      end
      STREAM: begin
        // sos from the owner mid-stream is plain data.
        if (own_c.valid && own_c.pe_tag == TAG) begin
          grant_c[owner] = 1'b1;
          accept_c       = 1'b1;
          if (own_c.eos) begin
            state_n = IDLE;
            rr_n    = bank_add(owner, 1);
          end
        end else if (timeout_hit_c) begin
          state_n = IDLE;
          rr_n    = bank_add(owner, 1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      state  <= state_n;
      rr_ptr <= rr_n;
      owner  <= owner_n;
    end
  end

  // Payload fields hold their last value between accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin : out_reg
    if (!rst_n) begin
      beat <= '0;
    end else begin
      beat.valid <= accept_c;
      if (accept_c) begin
        beat.sos      <= beats[sel_c].sos;
        beat.eos      <= beats[sel_c].eos;
        beat.num_iter <= beats[sel_c].num_iter;
        beat.nbr_id   <= beats[sel_c].nbr_id;
        beat.src_bank <= sel_c;
      end
    end
  end

`ifdef NEIGHBOR_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] stall_cnt;

  assign timeout_hit_c = (state == STREAM) && !own_c.valid &&
                         (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin : watchdog
    if (!rst_n) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state != STREAM || own_c.valid || timeout_hit_c) stall_cnt <= '0;
      else                                                  stall_cnt <= stall_cnt + CNT_W'(1);
      if (timeout_hit_c) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit_c = 1'b0;
  assign timeout_err   = 1'b0;
`endif

endmodule

// File: rtl/neighbor_stream_arbiter.sv
// Shares the Edge-PE neighbor-ID lanes between bank controllers, one locked stream per lane.
// Optional per-lane stall watchdog: NEIGHBOR_ARB_TIMEOUT_EN.
module neighbor_stream_arbiter
  import neighbor_stream_arbiter_pkg::*;
(
  input logic                      clk,
  input logic                      reset,
  neighbor_stream_arbiter_if.slave bus
);

  bank_beat_t [NUM_BANKS-1:0]           beats;
  logic [NUM_PE-1:0][NUM_BANKS-1:0]     lane_grant_c;
  logic [NUM_PE-1:0]                    lane_proto_c;
  pe_beat_t [NUM_PE-1:0]                pe_beat;
  logic [NUM_PE-1:0]                    lane_timeout;
  logic [NUM_BANKS-1:0]                 ready_c;
  logic                                 proto_err;

  // Unpack the flat bank bus into per-bank beats, broadcast to every lane.
  always_comb begin : steer
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      beats[b].valid    = bus.bank_valid[b];
      beats[b].pe_tag   = bus.bank_pe_tag[b*PE_TAG_W +: PE_TAG_W];
      beats[b].sos      = bus.bank_sos[b];
      beats[b].eos      = bus.bank_eos[b];
      beats[b].num_iter = bus.bank_num_iter[b*ITER_W +: ITER_W];
      beats[b].nbr_id   = bus.bank_nbr_id[b*NBR_ID_W +: NBR_ID_W];
    end
  end

  for (genvar l = 0; l < NUM_PE; l++) begin : g_lane
    neighbor_lane_rr_arb #(.LANE(l)) u_lane (
      .clk         (clk),
      .rst_n       (reset),
      .beats       (beats),
      .grant_c     (lane_grant_c[l]),
      .proto_c     (lane_proto_c[l]),
      .beat        (pe_beat[l]),
      .timeout_err (lane_timeout[l])
    );
  end

  // A bank's tag selects a single lane, so at most one lane grants it.
  always_comb begin : ready_or
    ready_c = '0;
    for (int unsigned l = 0; l < NUM_PE; l++) ready_c = ready_c | lane_grant_c[l];
  end

  assign bus.bank_ready = reset ? ready_c : '0;

  always_ff @(posedge clk or negedge reset) begin : proto_reg
    if (!reset) proto_err <= 1'b0;
    else        proto_err <= |lane_proto_c;
  end

  assign bus.proto_err   = proto_err;
  assign bus.timeout_err = lane_timeout;

  always_comb begin : pe_pack
    bus.pe_valid    = '0;
    bus.pe_sos      = '0;
    bus.pe_eos      = '0;
    bus.pe_num_iter = '0;
    bus.pe_nbr_id   = '0;
    bus.pe_src_bank = '0;
    for (int unsigned l = 0; l < NUM_PE; l++) begin
      bus.pe_valid[l]                        = pe_beat[l].valid;
      bus.pe_sos[l]                          = pe_beat[l].sos;
      bus.pe_eos[l]                          = pe_beat[l].eos;
      bus.pe_num_iter[l*ITER_W +: ITER_W]    = pe_beat[l].num_iter;
      bus.pe_nbr_id[l*NBR_ID_W +: NBR_ID_W]  = pe_beat[l].nbr_id;
      bus.pe_src_bank[l*BANK_W +: BANK_W]    = pe_beat[l].src_bank;
    end
  end

endmodule
